// File: rtl/memory_bank_io.sv
// memory_bank_io
//   Scan-chained memory bank with a memory-mapped IO window at the top of
//   the address space. The map is:
//     0 .. MEM_SIZE-1   general-purpose words
//     MEM_SIZE .. D-2   output registers, driven straight onto io_out_o
//     D-1               STATUS: synchronised pin levels in the low bits,
//                       sticky write-1-to-clear rising-edge flags from bit H
//   Every memory word, output register and edge flag is on one scan chain.
//   The pin synchronisers are not on the chain and keep sampling during scan.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   address_i        word address (full decode, every address readable)
//   data_in_i        write data
//   write_enable_i   write strobe, ignored while scanning
//   data_out_o       combinational read data for address_i
//   scan_enable_i    scan shift mode
//   scan_in_i        scan chain input
//   scan_out_o       scan chain output
//   io_in_i          asynchronous input pins
//   io_out_o         output register k on [k*DATA_WIDTH +: DATA_WIDTH]
module memory_bank_io #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_OUT    = 1,
    parameter int NUM_IN     = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [ADDR_WIDTH-1:0]         address_i,
    input  logic [DATA_WIDTH-1:0]         data_in_i,
    input  logic                          write_enable_i,
    output logic [DATA_WIDTH-1:0]         data_out_o,
    input  logic                          scan_enable_i,
    input  logic                          scan_in_i,
    output logic                          scan_out_o,
    input  logic [NUM_IN-1:0]             io_in_i,
    output logic [NUM_OUT*DATA_WIDTH-1:0] io_out_o
);

    localparam int D           = 2 ** ADDR_WIDTH;
    localparam int MEM_SIZE    = D - NUM_OUT - 1;
    localparam int H           = DATA_WIDTH / 2;
    localparam int STATUS_ADDR = D - 1;

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
    logic [DATA_WIDTH-1:0] mem_d [MEM_SIZE];
    logic [DATA_WIDTH-1:0] out_q [NUM_OUT];
    logic [DATA_WIDTH-1:0] out_d [NUM_OUT];
    logic [NUM_IN-1:0]     flag_q, flag_d;
    logic [NUM_IN-1:0]     sync1_q, sync2_q, prev_q;
    logic [NUM_IN-1:0]     rise;
    logic                  scan_carry;

    assign rise = sync2_q & ~prev_q;

    always_comb begin
        mem_d      = mem_q;
        out_d      = out_q;
        flag_d     = flag_q;
        scan_carry = scan_in_i;
        if (scan_enable_i) begin
            // scan_carry walks the chain: each register takes the MSB of the
            // register before it as its new LSB.
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_d[i]   = {mem_q[i][DATA_WIDTH-2:0], scan_carry};
                scan_carry = mem_q[i][DATA_WIDTH-1];
            end
            for (int k = 0; k < NUM_OUT; k++) begin
                out_d[k]   = {out_q[k][DATA_WIDTH-2:0], scan_carry};
                scan_carry = out_q[k][DATA_WIDTH-1];
            end
            flag_d = NUM_IN'({flag_q, scan_carry});
        end else begin
            if (write_enable_i) begin
                for (int i = 0; i < MEM_SIZE; i++) begin
                    if (address_i == ADDR_WIDTH'(i)) mem_d[i] = data_in_i;
                end
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (address_i == ADDR_WIDTH'(MEM_SIZE + k)) out_d[k] = data_in_i;
                end
                if (address_i == ADDR_WIDTH'(STATUS_ADDR)) begin
                    flag_d = flag_q & ~data_in_i[H +: NUM_IN];
                end
            end
            // Set is applied after the clear so a same-cycle edge wins.
            flag_d = flag_d | rise;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
            flag_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            out_q   <= out_d;
            flag_q  <= flag_d;
            sync1_q <= io_in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        data_out_o = '0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            if (address_i == ADDR_WIDTH'(i)) data_out_o = mem_q[i];
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (address_i == ADDR_WIDTH'(MEM_SIZE + k)) data_out_o = out_q[k];
        end
        if (address_i == ADDR_WIDTH'(STATUS_ADDR)) begin
            data_out_o[NUM_IN-1:0] = sync2_q;
            data_out_o[H +: NUM_IN] = flag_q;
        end
    end

    always_comb begin
        io_out_o = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            io_out_o[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
        end
    end

    assign scan_out_o = flag_q[NUM_IN-1];

endmodule
